// File: rtl/systolic_feed_ctrl.sv
// Feed controller for a ROW x COL systolic DataPath: loads weights and inputs into
// the row/column buffers, then drives the skewed read wavefront and waits for done.
module systolic_feed_ctrl #(
  parameter int WIDTH = 32,
  parameter int ROW   = 4,
  parameter int COL   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             done,
  output logic [WIDTH-1:0] data_in,
  output logic [ROW-1:0]   writew,
  output logic [COL-1:0]   writen,
  output logic [ROW-1:0]   readw,
  output logic [COL-1:0]   readn,
  output logic             cs,
  output logic             busy,
  output logic             finished
);

  localparam int CW = $clog2(ROW * COL + 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(ROW * COL - 1);
  localparam logic [CW-1:0] FEED_LAST = CW'(ROW + COL - 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_N,
    GAP,
    FEED,
    WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic [ROW-1:0]   writew_q, writew_d;
  logic [COL-1:0]   writen_q, writen_d;
  logic [ROW-1:0]   readw_q, readw_d;
  logic [COL-1:0]   readn_q, readn_d;
  logic             cs_q, cs_d;
  logic             busy_q, busy_d;
  logic             finished_q, finished_d;
  logic             accept;

  assign in_ready = (state_q == LOAD_W) || (state_q == LOAD_N);
  assign accept   = in_valid & in_ready;

  // One counter serves as word index while loading and as wavefront index in FEED.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          cnt_d   = '0;
        end
      end
      LOAD_W: begin
        if (accept) begin
          if (cnt_q == WORD_LAST) begin
            state_d = LOAD_N;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD_N: begin
        if (accept) begin
          if (cnt_q == WORD_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      GAP: begin
        state_d = FEED;
        cnt_d   = '0;
      end
      FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are registered, so every output appears one cycle after the state that produced it.
  always_comb begin
    data_in_d  = data_in_q;
    writew_d   = '0;
    writen_d   = '0;
    readw_d    = '0;
    readn_d    = '0;
    cs_d       = 1'b0;
    finished_d = 1'b0;
    busy_d     = (state_d != IDLE);
    if (accept) begin
      data_in_d = in_data;
    end
    case (state_q)
      LOAD_W: begin
        if (accept) begin
          writew_d = ROW'(1) << (cnt_q / CW'(COL));
        end
      end
      LOAD_N: begin
        if (accept) begin
          writen_d = COL'(1) << (cnt_q / CW'(ROW));
        end
      end
      FEED: begin
        cs_d = 1'b1;
        for (int i = 0; i < ROW; i++) begin
          if (i <= int'(cnt_q)) begin
            readw_d[i] = 1'b1;
          end
        end
        for (int j = 0; j < COL; j++) begin
          if (j <= int'(cnt_q)) begin
            readn_d[j] = 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        cs_d       = ~done;
        finished_d = done;
      end
      default: begin
        cs_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_in_q  <= '0;
      writew_q   <= '0;
      writen_q   <= '0;
      readw_q    <= '0;
      readn_q    <= '0;
      cs_q       <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_in_q  <= data_in_d;
      writew_q   <= writew_d;
      writen_q   <= writen_d;
      readw_q    <= readw_d;
      readn_q    <= readn_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
    end
  end

  assign data_in  = data_in_q;
  assign writew   = writew_q;
  assign writen   = writen_q;
  assign readw    = readw_q;
  assign readn    = readn_q;
  assign cs       = cs_q;
  assign busy     = busy_q;
  assign finished = finished_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Testbench for systolic_feed_ctrl: a 4x4 and a 2x4 instance driven through directed
// passes with randomized handshakes, compared against a word-count/wavefront model.
module tb_systolic_feed_ctrl;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   logic inValid;
   logic [W-1:0] inData;
   logic drvStart;
   logic drvDone;
   logic sel;

   logic start1, done1, start2, done2;

   logic inReady1, cs1, busy1, fin1;
   logic [W-1:0] dataIn1;
   logic [3:0] writew1, writen1, readw1, readn1;

   logic inReady2, cs2, busy2, fin2;
   logic [W-1:0] dataIn2;
   logic [1:0] writew2, readw2;
   logic [3:0] writen2, readn2;

   logic oReady, oCs, oBusy, oFin;
   logic [W-1:0] oData;
   logic [7:0] oWw, oWn, oRw, oRn;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] lastData [2];

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Steer the shared start/done drivers to whichever instance is under test
   assign start1 = drvStart & ~sel;
   assign done1  = drvDone & ~sel;
   assign start2 = drvStart & sel;
   assign done2  = drvDone & sel;

   // Unified view of the selected instance's outputs, zero-extended to 8 bits
   assign oReady = sel ? inReady2 : inReady1;
   assign oCs    = sel ? cs2 : cs1;
   assign oBusy  = sel ? busy2 : busy1;
   assign oFin   = sel ? fin2 : fin1;
   assign oData  = sel ? dataIn2 : dataIn1;
   assign oWw    = sel ? 8'(writew2) : 8'(writew1);
   assign oWn    = sel ? 8'(writen2) : 8'(writen1);
   assign oRw    = sel ? 8'(readw2) : 8'(readw1);
   assign oRn    = sel ? 8'(readn2) : 8'(readn1);

   systolic_feed_ctrl #(.WIDTH(W), .ROW(4), .COL(4)) u_dut (
      .clk(clk), .rst(rst), .start(start1), .in_valid(inValid), .in_data(inData),
      .in_ready(inReady1), .done(done1), .data_in(dataIn1), .writew(writew1),
      .writen(writen1), .readw(readw1), .readn(readn1), .cs(cs1), .busy(busy1),
      .finished(fin1)
   );

   systolic_feed_ctrl #(.WIDTH(W), .ROW(2), .COL(4)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .in_valid(inValid), .in_data(inData),
      .in_ready(inReady2), .done(done2), .data_in(dataIn2), .writew(writew2),
      .writen(writen2), .readw(readw2), .readn(readn2), .cs(cs2), .busy(busy2),
      .finished(fin2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] thermo(input int ones);
      return 8'((1 << ones) - 1);
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ready"}, 64'(oReady), 64'd0);
      checkOutput({tag, "_data"}, 64'(oData), 64'd0);
      checkOutput({tag, "_writew"}, 64'(oWw), 64'd0);
      checkOutput({tag, "_writen"}, 64'(oWn), 64'd0);
      checkOutput({tag, "_readw"}, 64'(oRw), 64'd0);
      checkOutput({tag, "_readn"}, 64'(oRn), 64'd0);
      checkOutput({tag, "_cs"}, 64'(oCs), 64'd0);
      checkOutput({tag, "_busy"}, 64'(oBusy), 64'd0);
      checkOutput({tag, "_finished"}, 64'(oFin), 64'd0);
   endtask

   // One load/compute pass. validMode: 0 always valid, 1 toggling during weight load,
   // 2 random. abortAt >= 0 resets the block once that many words have been accepted.
   task automatic applyStimulus(input int r, input int c, input int validMode, input bit seqData,
                                input int abortAt, input bit startInFeed, input bit doneInLoad,
                                input int doneDelay);
      int n;
      int k;
      int cyc;
      int j;
      bit v;
      logic [W-1:0] word;
      logic [7:0] expW, expN;
      n = r * c;
      k = 0;
      cyc = 0;
      word = '0;

      checkOutput("idle_ready", 64'(oReady), 64'd0);
      checkOutput("idle_busy", 64'(oBusy), 64'd0);
      checkOutput("idle_data", 64'(oData), 64'(lastData[sel]));
      drvStart = 1'b1;
      drvDone = doneInLoad;
      tick();
      drvStart = 1'b0;
      checkOutput("start_busy", 64'(oBusy), 64'd1);
      checkOutput("start_writew", 64'(oWw), 64'd0);

      while (k < 2 * n && cyc < 20 * n) begin
         if (abortAt >= 0 && k == abortAt) break;
         if (validMode == 0) v = 1'b1;
         else if (validMode == 1) v = (k < n) ? (cyc % 2 == 0) : 1'b1;
         else v = 1'($urandom_range(0, 1));
         if (seqData) begin
            if (k < n) word = W'(k + 1);
            else begin
               j = k - n;
               word = W'((j % r) * c + j / r + 1);
            end
         end else if (k >= 0) begin
            word = (v) ? $urandom : word;
         end
         inValid = v;
         inData = v ? word : $urandom;
         checkOutput("load_ready", 64'(oReady), 64'd1);
         tick();
         if (v) begin
            if (k < n) begin
               expW = 8'(1 << (k / c));
               expN = 8'd0;
            end else begin
               expW = 8'd0;
               expN = 8'(1 << ((k - n) / r));
            end
            lastData[sel] = word;
            k++;
         end else begin
            expW = 8'd0;
            expN = 8'd0;
         end
         checkOutput("writew", 64'(oWw), 64'(expW));
         checkOutput("writen", 64'(oWn), 64'(expN));
         checkOutput("data_in", 64'(oData), 64'(lastData[sel]));
         checkOutput("load_readw", 64'(oRw), 64'd0);
         checkOutput("load_cs", 64'(oCs), 64'd0);
         cyc++;
      end
      inValid = 1'b0;

      if (abortAt >= 0) begin
         checkOutput("abort_words", 64'(k), 64'(abortAt));
         rst = 1'b0;
         #1;
         checkAllZero("abort");
         tick();
         checkAllZero("abort_hold");
         rst = 1'b1;
         drvDone = 1'b0;
         lastData[0] = '0;
         lastData[1] = '0;
         return;
      end
      checkOutput("load_count", 64'(k), 64'(2 * n));
      drvDone = 1'b0;

      checkOutput("gap_ready", 64'(oReady), 64'd0);
      tick();
      checkOutput("gap_writew", 64'(oWw), 64'd0);
      checkOutput("gap_writen", 64'(oWn), 64'd0);
      checkOutput("gap_readw", 64'(oRw), 64'd0);
      checkOutput("gap_readn", 64'(oRn), 64'd0);
      checkOutput("gap_cs", 64'(oCs), 64'd0);
      checkOutput("gap_busy", 64'(oBusy), 64'd1);

      for (int f = 0; f < r + c - 1; f++) begin
         if (startInFeed && f == 1) drvStart = 1'b1;
         tick();
         drvStart = 1'b0;
         checkOutput("feed_readw", 64'(oRw), 64'(thermo(imin(f + 1, r))));
         checkOutput("feed_readn", 64'(oRn), 64'(thermo(imin(f + 1, c))));
         checkOutput("feed_cs", 64'(oCs), 64'd1);
         checkOutput("feed_writew", 64'(oWw), 64'd0);
         checkOutput("feed_ready", 64'(oReady), 64'd0);
         checkOutput("feed_data", 64'(oData), 64'(lastData[sel]));
      end

      for (int d = 0; d < doneDelay; d++) begin
         tick();
         checkOutput("wait_readw", 64'(oRw), 64'd0);
         checkOutput("wait_readn", 64'(oRn), 64'd0);
         checkOutput("wait_cs", 64'(oCs), 64'd1);
         checkOutput("wait_finished", 64'(oFin), 64'd0);
         checkOutput("wait_busy", 64'(oBusy), 64'd1);
      end

      drvDone = 1'b1;
      tick();
      drvDone = 1'b0;
      checkOutput("end_cs", 64'(oCs), 64'd0);
      checkOutput("end_finished", 64'(oFin), 64'd1);
      checkOutput("end_busy", 64'(oBusy), 64'd0);
      tick();
      checkOutput("post_finished", 64'(oFin), 64'd0);
      checkOutput("post_cs", 64'(oCs), 64'd0);
      checkOutput("post_busy", 64'(oBusy), 64'd0);
   endtask

   // Directed sequence of passes on both instances, then the summary
   initial begin
      rst = 1'b0;
      inValid = 1'b0;
      inData = '0;
      drvStart = 1'b0;
      drvDone = 1'b0;
      sel = 1'b0;
      lastData[0] = '0;
      lastData[1] = '0;
      #3;
      checkAllZero("reset");
      sel = 1'b1;
      #1;
      checkAllZero("reset2");
      sel = 1'b0;
      tick();
      tick();
      checkAllZero("reset_clk");
      rst = 1'b1;
      tick();

      $display("[TB] 4x4 sequential pass");
      applyStimulus(4, 4, 0, 1'b1, -1, 1'b0, 1'b0, 4);
      $display("[TB] 4x4 toggling valid");
      applyStimulus(4, 4, 1, 1'b0, -1, 1'b0, 1'b0, 2);
      $display("[TB] 4x4 random valid, start during feed");
      applyStimulus(4, 4, 2, 1'b0, -1, 1'b1, 1'b0, 0);
      $display("[TB] 4x4 done held during load");
      applyStimulus(4, 4, 2, 1'b0, -1, 1'b0, 1'b1, 3);
      $display("[TB] 4x4 reset mid input load");
      applyStimulus(4, 4, 0, 1'b0, 16 + 6, 1'b0, 1'b0, 0);
      tick();
      applyStimulus(4, 4, 0, 1'b1, -1, 1'b0, 1'b0, 1);

      $display("[TB] 2x4 random pass");
      sel = 1'b1;
      tick();
      applyStimulus(2, 4, 2, 1'b0, -1, 1'b0, 1'b0, 1);
      applyStimulus(2, 4, 0, 1'b1, -1, 1'b1, 1'b0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_feed_ctrl.md
SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width.
REQ-002 SHALL have parameter ROW, default 4, meaning weight rows of the downstream DataPath.
REQ-003 SHALL have parameter COL, default 4, meaning input columns of the downstream DataPath.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load/compute pass.
REQ-007 SHALL have port in_valid  input  1  upstream word valid.
REQ-008 SHALL have port in_data  input  WIDTH  upstream word.
REQ-009 SHALL have port in_ready  output  1  controller accepts in_data this cycle.
REQ-010 SHALL have port done  input  1  completion flag from DataPath.
REQ-011 SHALL have port data_in  output  WIDTH  registered word to DataPath.
REQ-012 SHALL have ports writew  output  ROW and writen  output  COL  one-hot buffer write strobes.
REQ-013 SHALL have ports readw  output  ROW and readn  output  COL  skewed read enables.
REQ-014 SHALL have port cs  output  1  DataPath compute select.
REQ-015 SHALL have ports busy  output  1 (not IDLE) and finished  output  1 (one-cycle pass-complete pulse).

Function
REQ-016 SHALL implement states IDLE, LOAD_W, LOAD_N, GAP, FEED, WAIT_DONE.
REQ-017 IDLE -> LOAD_W on start=1; start in any other state SHALL be ignored.
REQ-018 in_ready SHALL be 1 only in LOAD_W and LOAD_N; a word is accepted when in_valid & in_ready.
REQ-019 LOAD_W: ROW*COL words accepted in row-major order; word k SHALL drive data_in=in_data and writew=1<<(k/COL) on the cycle after acceptance (latency 1).
REQ-020 LOAD_N: ROW*COL words; word k SHALL drive data_in=in_data and writen=1<<(k/ROW) on the cycle after acceptance.
REQ-021 Cycle after a non-accept cycle: writew and writen SHALL be 0, data_in SHALL hold its last value.
REQ-022 Last LOAD_W accept -> LOAD_N; last LOAD_N accept -> GAP; counters SHALL reset to 0 on each transition.
REQ-023 GAP SHALL last exactly 1 cycle with all strobes 0; cs SHALL rise to 1 on entering FEED.
REQ-024 FEED SHALL last ROW+COL-1 cycles; in feed cycle f (0-based) readw SHALL be thermometer mask of min(f+1,ROW) ones from LSB and readn of min(f+1,COL) ones.
REQ-025 After FEED -> WAIT_DONE: readw=readn=0, cs held 1 until done sampled 1.
REQ-026 On done=1 in WAIT_DONE: next cycle cs=0, finished=1 for exactly one cycle, state IDLE.
REQ-027 done outside WAIT_DONE SHALL be ignored.
REQ-028 Word/row counters SHALL be sized clog2(ROW*COL+1) and SHALL never wrap within a pass.
REQ-029 All outputs SHALL be registered (no combinational path input -> output except in_ready from state).

Reset
REQ-030 rst=0 SHALL asynchronously force IDLE, counters 0, data_in=0, all strobes 0, cs=0, busy=0, finished=0, in_ready=0.
REQ-031 Reset mid-pass SHALL abandon the pass; after rst=1 the block SHALL wait for a new start.

Verification
REQ-032 Full pass, in_valid always 1, words 1..16 then 1,5,9,13,2,...,16 -> writew 0001 x4,0010 x4,0100 x4,1000 x4 with data 1..16; writen 0001 for 1,5,9,13 etc.; 1 GAP cycle; readw/readn 0001,0011,0111,1111,1111,1111,1111; done after 4 cycles -> cs falls, finished pulse.
REQ-033 in_valid toggled 1,0,1,0 during LOAD_W -> strobes only on cycles after accepts; data_in stable on idle cycles; total 16 strobes.
REQ-034 start pulsed during FEED -> no effect; pass completes normally.
REQ-035 done held 1 throughout LOAD_W -> ignored; WAIT_DONE entered, exits on first cycle with done=1.
REQ-036 rst=0 asserted mid-LOAD_N (after 6 words) -> all outputs 0 immediately; new start reloads from weight word 0.
REQ-037 ROW=2, COL=4 -> FEED 5 cycles: readw 01,11,11,11,11; readn 0001,0011,0111,1111,1111.
